// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
// univ_shift_reg : falling-edge universal shift/rotate/load/count register
// Rev 1.0
// ============================================================================
module univ_shift_reg #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int              CNT_W     = $clog2(WIDTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic [2:0]       mode,
   input  logic             ser_in_r,
   input  logic             ser_in_l,
   input  logic [WIDTH-1:0] par_in,
   output logic [WIDTH-1:0] q,
   output logic             ser_out_r,
   output logic             ser_out_l,
   output logic             carry,
   output logic [CNT_W-1:0] shift_cnt,
   output logic             drained
);

   localparam logic [2:0] c_MODE_HOLD = 3'b000;
   localparam logic [2:0] c_MODE_SHR  = 3'b001;
   localparam logic [2:0] c_MODE_SHL  = 3'b010;
   localparam logic [2:0] c_MODE_LOAD = 3'b011;
   localparam logic [2:0] c_MODE_ROR  = 3'b100;
   localparam logic [2:0] c_MODE_ROL  = 3'b101;
   localparam logic [2:0] c_MODE_UP   = 3'b110;
   localparam logic [2:0] c_MODE_DN   = 3'b111;

   localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(WIDTH);

   logic [WIDTH-1:0] r_q;
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;

   logic [WIDTH-1:0] w_q_next;
   logic             w_carry_next;
   logic [CNT_W-1:0] w_cnt_next;
   logic [CNT_W-1:0] w_cnt_inc;

   // The shift count saturates so drained stays asserted until a load/clear.
   assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

   always_comb begin
      w_q_next     = r_q;
      w_carry_next = 1'b0;
      w_cnt_next   = r_cnt;
      if (enable) begin
         case (mode)
            c_MODE_HOLD: w_q_next = r_q;
            c_MODE_SHR: begin
               w_q_next   = {ser_in_r, r_q[WIDTH-1:1]};
               w_cnt_next = w_cnt_inc;
            end
            c_MODE_SHL: begin
               w_q_next   = {r_q[WIDTH-2:0], ser_in_l};
               w_cnt_next = w_cnt_inc;
            end
            c_MODE_LOAD: begin
               w_q_next   = par_in;
               w_cnt_next = '0;
            end
            c_MODE_ROR: begin
               w_q_next   = {r_q[0], r_q[WIDTH-1:1]};
               w_cnt_next = w_cnt_inc;
            end
            c_MODE_ROL: begin
               w_q_next   = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
               w_cnt_next = w_cnt_inc;
            end
            c_MODE_UP: begin
               w_q_next     = r_q + WIDTH'(1);
               w_carry_next = &r_q;
            end
            c_MODE_DN: begin
               w_q_next     = r_q - WIDTH'(1);
               w_carry_next = ~|r_q;
            end
            default: w_q_next = r_q;
         endcase
      end
   end

   // All state moves on the falling edge; reset is asynchronous, active-low.
   always_ff @(negedge clock or negedge reset) begin
      if (!reset) begin
         r_q     <= RESET_VAL;
         r_carry <= 1'b0;
         r_cnt   <= '0;
      end else if (clear) begin
         r_q     <= RESET_VAL;
         r_carry <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_q     <= w_q_next;
         r_carry <= w_carry_next;
         r_cnt   <= w_cnt_next;
      end
   end

   assign q         = r_q;
   assign carry     = r_carry;
   assign shift_cnt = r_cnt;
   assign ser_out_r = r_q[0];
   assign ser_out_l = r_q[WIDTH-1];
   assign drained   = (r_cnt == c_CNT_MAX);

endmodule
`default_nettype wire
